// File: rtl/sub_pkg.sv
// sub_pkg: shared state type and counter-width helper for the serial subtractor
package sub_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction
endpackage

// File: rtl/full_sub.sv
// full_sub: one-bit combinational full subtractor
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic diff,
  output logic bo
);
  assign diff = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial LSB-first subtractor with start/busy/done handshake and registered flags
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bi_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             bo_out,
  output logic             ovf_out,
  output logic             zero_out
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, res;
  logic [WIDTH:0] cat;
  logic [CW-1:0] cnt;
  logic br, sa, sb, cd, cb, last;
  full_sub u_cell (.a(a_sr[0]), .b(b_sr[0]), .bi(br), .diff(cd), .bo(cb));
  assign last = cnt == CW'(WIDTH - 1);
  assign cat = {cd, d_sr} >> 1;
  assign res = cat[WIDTH-1:0];
  assign busy_out = state == RUN;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (start_in ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      cnt <= '0;
      done_out <= 1'b0;
      diff_out <= '0;
      bo_out <= 1'b0;
      ovf_out <= 1'b0;
      zero_out <= 1'b0;
    end else if (state == IDLE) begin
      done_out <= 1'b0;
      if (start_in) begin
        a_sr <= a_in;
        b_sr <= b_in;
        br <= bi_in;
        sa <= a_in[WIDTH-1];
        sb <= b_in[WIDTH-1];
        cnt <= '0;
      end
    end else begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= res;
      br <= cb;
      cnt <= last ? cnt : cnt + 1'b1;
      done_out <= last;
      if (last) begin
        diff_out <= res;
        bo_out <= cb;
        ovf_out <= (sa != sb) && (res[WIDTH-1] != sa);
        zero_out <= ~|res;
      end
    end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Parametrised bit-serial N-bit subtractor. Computes diff = a − b − borrow_in, one bit per clock, LSB first.
- Reuses a single combinational full-subtractor cell each cycle, plus a borrow flip-flop, shift registers and a bit counter.
- Sits in the arithmetic datapath where area matters more than latency.
- Adds a start/busy/done handshake, borrow-in, and registered flags (borrow, signed overflow, zero).

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH ≥ 1.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  minuend; sampled on the edge that accepts start_in.
- b_in  input  WIDTH  subtrahend; sampled on the edge that accepts start_in.
- bi_in  input  1  borrow-in; sampled on the edge that accepts start_in.
- busy_out  output  1  high while an operation is in progress.
- done_out  output  1  one-cycle pulse; result outputs are updated in the same cycle.
- diff_out  output  WIDTH  result, a − b − bi, modulo 2^WIDTH.
- bo_out  output  1  final borrow-out; 1 when the unsigned result is negative.
- ovf_out  output  1  signed (two's-complement) overflow.
- zero_out  output  1  1 when diff_out is all zeros.

Behaviour:
- **Reset.** Asynchronous, active-low. Any time rst_n_in = 0, including mid-operation:
  - state goes to IDLE; busy_out = 0, done_out = 0;
  - diff_out = 0, bo_out = 0, ovf_out = 0, zero_out = 0;
  - shift registers, borrow flip-flop and counter are cleared;
  - any operation in progress is aborted with no done_out.
- **States.**
  - IDLE: start_in = 1 at an edge loads a_in, b_in and bi_in (borrow flip-flop ← bi_in), sets count = 0, goes to RUN, and sets busy_out = 1.
  - RUN: each edge feeds the LSBs of the a and b shift registers and the borrow flip-flop into the cell.
    - diff bit shifts into the MSB of the result shift register; operand registers shift right.
    - borrow flip-flop ← cell borrow; count increments.
    - On the edge that processes bit WIDTH−1: go to IDLE, busy_out ← 0, done_out ← 1.
    - On that same edge, diff_out, bo_out and zero_out are registered from the completed result.
    - ovf_out ← (a[W−1] ≠ b[W−1]) && (diff[W−1] ≠ a[W−1]). The a and b sign bits are captured at load.
  - Any other edge: done_out ← 0.
- **Latency.** If start is accepted at edge t, done_out is high between edges t+WIDTH and t+WIDTH+1. busy_out is high from edge t+1 through edge t+WIDTH. Minimum issue interval is WIDTH+1 cycles.
- **Handshake rules.**
  - start_in while busy_out = 1 is ignored: no queuing, no effect on the running operation.
  - start_in during the done_out cycle is accepted, because the state is already IDLE.
  - Operand inputs are don't-care except on the accepting edge.
- **Output hold.** diff_out and the flags hold the last result until the next completion. They do not change when a new start is accepted.
- **Counter.** Width is max(1, clog2(WIDTH)) and it stops at WIDTH−1, with no wrap beyond it.
- **WIDTH = 1.** Single RUN cycle; behaves as a registered full subtractor with 1-cycle compute latency.
- **Borrow semantics.**
  - bo_out = 1 iff a < b + bi as unsigned values.
  - bi_in = 1 with a = b gives diff = all ones and bo_out = 1.

Decomposition:
- **Package sub_pkg:**
  - state typedef (IDLE, RUN);
  - function cnt_w(width) returning max(1, clog2(width)).
- **Sub-module full_sub (combinational):**
  - inputs: a bit, b bit, borrow-in;
  - diff = a ^ b ^ bi;
  - bo = (~a & b) | (~(a ^ b) & bi).
  - Instantiated once in serial_sub.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, bi=0, start at edge t → done_out high only between edges t+8 and t+9; diff=8'h1E, bo=0, ovf=0, zero=0; busy_out high for exactly 8 cycles.
- a=8'h00, b=8'h01, bi=0 → diff=8'hFF, bo=1, ovf=0. Then a=8'h80, b=8'h01 → diff=8'h7F, bo=0, ovf=1.
- a=8'h10, b=8'h0F, bi=1 → diff=8'h00, zero=1, bo=0. Then a=8'h05, b=8'h05, bi=1 → diff=8'hFF, bo=1, zero=0.
- Start, then pulse start_in with a different operand at cycle t+3 → ignored; only one done_out, with the first result. A start during the done cycle is accepted and completes at +8.
- Deassert rst_n_in mid-RUN (count=4) → all outputs 0 immediately, without waiting for a clock edge. After release, no done_out until a new start; the new operation completes correctly.
- WIDTH=1 instance, exhaustive over a, b, bi (8 cases) → done 1 edge after start; diff/bo match the full-subtractor truth table.
